// File: rtl/mem_pkg.sv
// Shared memory-map constants and RAM controller state encoding.
// Both the bus mux and the windowed RAMs take their window defaults from here.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RAM_BASE  = 128;
    localparam int RAM_DEPTH = 96;

    // Word-index width for a window of the given depth, with a minimum of one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_window_sync_if.sv
// Request/response bundle between a bus master and a windowed RAM.
// The master drives requests; the RAM returns ready, the response strobe and the sweep status.
interface ram_window_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] ram_data_out;
    logic              busy;

    modport master (
        output req_valid, we, address, data_in,
        input  req_ready, rsp_valid, rsp_err, ram_data_out, busy
    );

    modport slave (
        input  req_valid, we, address, data_in,
        output req_ready, rsp_valid, rsp_err, ram_data_out, busy
    );
endinterface

// File: rtl/addr_window_decode.sv
// Address window decode: flags addresses in [BASE, BASE+DEPTH-1] and gives the word index.
// Latency: combinational; backpressure: none.
module addr_window_decode
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = RAM_BASE,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic [ADDR_W-1:0] address,
    output logic              in_win,
    output logic [IDX_W-1:0]  index
);

    // One extra bit so BASE+DEPTH-1 at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] LO = (ADDR_W + 1)'(BASE);
    localparam logic [ADDR_W:0] HI = (ADDR_W + 1)'(BASE + DEPTH - 1);

    always_comb begin
        in_win = ({1'b0, address} >= LO) && ({1'b0, address} <= HI);
        index  = IDX_W'(address - ADDR_W'(BASE));
    end

endmodule

// File: rtl/ram_window_sync.sv
// Single-port windowed RAM with optional post-reset zero sweep and out-of-window error response.
// Latency: 1 cycle request-to-response; backpressure: req_ready low during reset and the clear sweep.
module ram_window_sync
    import mem_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int BASE           = RAM_BASE,
    parameter int DEPTH          = RAM_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_window_sync_if.slave bus
);

    localparam int     IDX_W     = idx_width(DEPTH);
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    if (DEPTH < 1 || BASE < 0 || (BASE + DEPTH) > (1 << ADDR_W)) begin : g_bad_window
        $error("ram_window_sync: window BASE=%0d DEPTH=%0d does not fit a %0d-bit bus",
               BASE, DEPTH, ADDR_W);
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] dout_q;
    logic              in_win;
    logic [IDX_W-1:0]  index;
    logic              accept;
    logic [DATA_W-1:0] mem [DEPTH];

    addr_window_decode #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_decode (
        .address (bus.address),
        .in_win  (in_win),
        .index   (index)
    );

    assign accept = bus.req_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is registered so it stays low for the first cycle out of reset even with no sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            clr_idx_q   <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && !in_win;
            if (accept && !bus.we && in_win) begin
                dout_q <= mem[index];
            end
        end
    end

    // Array has no reset; the sweep (when enabled) is the only initialisation.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (accept && bus.we && in_win) begin
            mem[index] <= bus.data_in;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.ram_data_out = dout_q;
    assign bus.busy         = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_window_sync.sv
// Directed plus randomized bench for ram_window_sync: default 96x8 window with sweep,
// and a 256x16 window at 512 without sweep, both checked against an address-keyed model.
module tb_ram_window_sync;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_window_sync_if #(.DATA_W(8),  .ADDR_W(8))  bus_a ();
    ram_window_sync_if #(.DATA_W(16), .ADDR_W(10)) bus_b ();

    ram_window_sync u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ram_window_sync #(
        .DATA_W         (16),
        .ADDR_W         (10),
        .BASE           (512),
        .DEPTH          (256),
        .CLEAR_ON_RESET (0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference contents keyed by bus address; absent entries of A read as zero after a sweep.
    logic [7:0]  ref_a [int];
    logic [15:0] ref_b [int];
    logic [7:0]  exp_dout_a = '0;
    logic [15:0] exp_dout_b = '0;

    function automatic bit in_a(input int addr);
        return (addr >= 128) && (addr < 128 + 96);
    endfunction

    function automatic bit in_b(input int addr);
        return (addr >= 512) && (addr < 512 + 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on bus A: present (optionally) a request, then check the response one cycle later.
    task automatic cyc_a(input string tag, input bit v, input bit w, input int addr, input logic [7:0] d);
        bit exp_err;
        bus_a.req_valid = v;
        bus_a.we        = w;
        bus_a.address   = addr[7:0];
        bus_a.data_in   = d;
        if (v) chk($sformatf("%s.rdy", tag), bus_a.req_ready, 1);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        exp_err = v && !in_a(addr);
        if (v && in_a(addr)) begin
            if (w) ref_a[addr] = d;
            else   exp_dout_a = ref_a.exists(addr) ? ref_a[addr] : 8'h00;
        end
        chk($sformatf("%s.vld", tag), bus_a.rsp_valid, v);
        if (v) chk($sformatf("%s.err", tag), bus_a.rsp_err, exp_err);
        chk($sformatf("%s.dat", tag), bus_a.ram_data_out, exp_dout_a);
    endtask

    task automatic cyc_b(input string tag, input bit v, input bit w, input int addr, input logic [15:0] d);
        bit exp_err;
        bus_b.req_valid = v;
        bus_b.we        = w;
        bus_b.address   = addr[9:0];
        bus_b.data_in   = d;
        if (v) chk($sformatf("%s.rdy", tag), bus_b.req_ready, 1);
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        exp_err = v && !in_b(addr);
        if (v && in_b(addr)) begin
            if (w) ref_b[addr] = d;
            else if (ref_b.exists(addr)) exp_dout_b = ref_b[addr];
        end
        chk($sformatf("%s.vld", tag), bus_b.rsp_valid, v);
        if (v) chk($sformatf("%s.err", tag), bus_b.rsp_err, exp_err);
        chk($sformatf("%s.dat", tag), bus_b.ram_data_out, exp_dout_b);
    endtask

    // Counts cycles of busy on A after reset release; ready and responses must stay quiet meanwhile.
    task automatic sweep_a(input string tag);
        int n;
        bit noisy;
        n = 0;
        noisy = 1'b0;
        while (bus_a.busy === 1'b1 && n < 1000) begin
            if (bus_a.req_ready !== 1'b0 || bus_a.rsp_valid !== 1'b0) noisy = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s.len", tag), n, 96);
        chk($sformatf("%s.quiet", tag), noisy, 0);
        chk($sformatf("%s.rdy_after", tag), bus_a.req_ready, 1);
        chk($sformatf("%s.vld_after", tag), bus_a.rsp_valid, 0);
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.we = 1'b0; bus_a.address = '0; bus_a.data_in = '0;
        bus_b.req_valid = 1'b0; bus_b.we = 1'b0; bus_b.address = '0; bus_b.data_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.a_rdy",  bus_a.req_ready, 0);
        chk("rst.a_vld",  bus_a.rsp_valid, 0);
        chk("rst.a_err",  bus_a.rsp_err, 0);
        chk("rst.a_dat",  bus_a.ram_data_out, 0);
        chk("rst.a_busy", bus_a.busy, 1);
        chk("rst.b_busy", bus_b.busy, 0);
        chk("rst.b_rdy",  bus_b.req_ready, 0);

        // Sweep with a write held on the bus; it must be ignored
        bus_a.req_valid = 1'b1; bus_a.we = 1'b1; bus_a.address = 8'd128; bus_a.data_in = 8'h55;
        rst_n = 1'b1;
        sweep_a("sweep1");
        bus_a.req_valid = 1'b0;

        cyc_a("t1.rd128", 1, 0, 128, 8'h00);
        cyc_a("t1.rd175", 1, 0, 175, 8'h00);
        cyc_a("t1.rd223", 1, 0, 223, 8'h00);

        cyc_a("t2.wr128", 1, 1, 128, 8'hA5);
        cyc_a("t2.wr223", 1, 1, 223, 8'h3C);
        cyc_a("t2.rd223", 1, 0, 223, 8'h00);
        cyc_a("t2.rd128", 1, 0, 128, 8'h00);

        cyc_a("t3.rd127", 1, 0, 127, 8'h00);
        cyc_a("t3.rd224", 1, 0, 224, 8'h00);
        cyc_a("t3.wr127", 1, 1, 127, 8'hFF);
        cyc_a("t3.rd128", 1, 0, 128, 8'h00);
        cyc_a("t3.rd0",   1, 0, 0,   8'h00);
        cyc_a("t3.wr255", 1, 1, 255, 8'h77);

        cyc_a("t4.wr150", 1, 1, 150, 8'h11);
        cyc_a("t4.rd150", 1, 0, 150, 8'h00);
        cyc_a("t4.idle",  0, 0, 0,   8'h00);

        for (int i = 0; i < 300; i++) begin
            cyc_a("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(120, 231), 8'($urandom));
        end

        // Mid-sweep reset: outputs clear asynchronously and the sweep restarts from scratch
        cyc_a("t5.wr200", 1, 1, 200, 8'h5A);
        cyc_a("t5.rd200", 1, 0, 200, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_dout_a = '0;
        chk("t5.async_vld",  bus_a.rsp_valid, 0);
        chk("t5.async_dat",  bus_a.ram_data_out, 0);
        chk("t5.async_rdy",  bus_a.req_ready, 0);
        chk("t5.async_busy", bus_a.busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t5.busy40", bus_a.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5.rst40_busy", bus_a.busy, 1);
        chk("t5.rst40_rdy",  bus_a.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_a("sweep2");
        ref_a.delete();
        cyc_a("t5.rd200", 1, 0, 200, 8'h00);
        cyc_a("t5.rd150", 1, 0, 150, 8'h00);

        // Variant without sweep: ready on the first edge after release
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_dout_b = '0;
        chk("t6.rst_rdy", bus_b.req_ready, 0);
        chk("t6.rst_vld", bus_b.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6.rel_rdy",  bus_b.req_ready, 0);
        chk("t6.rel_busy", bus_b.busy, 0);
        @(posedge clk);
        #1;
        chk("t6.first_rdy", bus_b.req_ready, 1);
        cyc_b("t6.wr767", 1, 1, 767, 16'hBEEF);
        cyc_b("t6.rd767", 1, 0, 767, 16'h0000);
        cyc_b("t6.rd768", 1, 0, 768, 16'h0000);
        cyc_b("t6.wr512", 1, 1, 512, 16'h1234);
        cyc_b("t6.rd511", 1, 0, 511, 16'h0000);
        cyc_b("t6.rd512", 1, 0, 512, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            cyc_b("rndb_wr", 1, 1, $urandom_range(500, 780), 16'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(500, 780);
            if (!in_b(a) || ref_b.exists(a)) cyc_b("rndb_rd", 1, 0, a, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_window_sync.md
Name: ram_window_sync

Overview:
Parametrised single-port synchronous RAM. It answers only to addresses inside a configurable window [BASE, BASE+DEPTH-1] of a shared ADDR_W-bit bus. It generalises the fixed 96x8 window RAM with:
- parameters for data width, address width, base and depth;
- a valid/ready request handshake and a response strobe;
- an out-of-window error flag;
- an optional post-reset clear sweep that zeroes every word before the first access.

It sits on the memory-system address bus beside other windowed memories and the bus mux.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, bus address width in bits
BASE, 128, first address decoded by this RAM
DEPTH, 96, number of words; window is BASE..BASE+DEPTH-1
CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = skip the sweep

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present this cycle
req_ready  output  1  RAM can accept a request this cycle
we  input  1  1 = write, 0 = read; sampled with the request
address  input  ADDR_W  bus address; sampled with the request
data_in  input  DATA_W  write data; sampled with the request
rsp_valid  output  1  one-cycle pulse, one cycle after each accepted request
rsp_err  output  1  qualified by rsp_valid; 1 = request address was outside the window
ram_data_out  output  DATA_W  read data, qualified by rsp_valid on reads
busy  output  1  high while the clear sweep runs

Behaviour:
- Elaboration check: DEPTH >= 1 and BASE+DEPTH <= 2**ADDR_W; fail elaboration otherwise.
- Window decode:
  - in_win = (address >= BASE) && (address <= BASE+DEPTH-1), unsigned, combinational.
  - Word index = address - BASE, width clog2(DEPTH).
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_err=0, ram_data_out=0, req_ready=0.
  - State -> CLEAR when CLEAR_ON_RESET=1 (busy=1, clear index=0); state -> IDLE otherwise (busy=0).
  - Array contents are not reset by rst_n.
- State CLEAR:
  - Writes 0 to word[idx] each cycle and increments idx.
  - After writing idx=DEPTH-1, moves to IDLE on the next edge, so the sweep takes exactly DEPTH cycles after reset release.
  - req_ready=0 and busy=1 throughout; req_valid is ignored and has no side effects.
  - rst_n asserted mid-sweep restarts the sweep from idx 0.
- State IDLE:
  - req_ready=1 and busy=0.
  - A request is accepted on an edge where req_valid && req_ready.
- Accepted write, in window: word[index] <= data_in. Next cycle: rsp_valid=1, rsp_err=0, ram_data_out unchanged.
- Accepted read, in window: next cycle rsp_valid=1, rsp_err=0, ram_data_out = word[index]. Latency is exactly 1 cycle.
- Accepted request, out of window: no array access. Next cycle rsp_valid=1, rsp_err=1, ram_data_out holds its previous value.
- ram_data_out holds its value until the next in-window read response.
- Throughput: one request per cycle. Back-to-back read-after-write to the same address returns the newly written data, because the write is committed at acceptance.
- Address X/Z handling: not defined; the bench must always drive valid addresses with req_valid.

Decomposition:
- Shared package mem_pkg:
  - state encoding (ST_CLEAR, ST_IDLE);
  - default window constants for the memory map (RAM_BASE=128, RAM_DEPTH=96), so the bus mux and this RAM share one source.
- One natural sub-module, addr_window_decode: combinational in_win and index from address with BASE/DEPTH parameters. The bus mux can reuse it.

Test Plan:
1. Reset and clear sweep, defaults: release rst_n -> busy=1 and req_ready=0 for exactly 96 cycles, then req_ready=1. Read 128, 175 and 223 -> rsp_valid pulse with ram_data_out=0x00, rsp_err=0.
2. Write then read: write 0xA5 to 128 and 0x3C to 223 -> each gives one rsp_valid pulse with rsp_err=0. Read 223 then 128 back-to-back -> 0x3C then 0xA5 on consecutive cycles.
3. Window edges: read 127 and read 224 -> rsp_err=1, ram_data_out keeps its prior value 0xA5. Write 0xFF to 127 -> rsp_err=1, then read 128 still returns 0xA5.
4. Read-after-write same address: write 0x11 to 150 in cycle n, read 150 in cycle n+1 -> response in cycle n+2 is 0x11.
5. Reset mid-sweep: assert rst_n low at sweep cycle 40, release -> busy stays high for a full 96 more cycles. rsp_valid=0 and ram_data_out=0 immediately on rst_n low.
6. Parameter variant DATA_W=16, ADDR_W=10, BASE=512, DEPTH=256, CLEAR_ON_RESET=0 -> req_ready=1 on the first edge after reset. Write 0xBEEF to 767 and read it back -> 0xBEEF. Read 768 -> rsp_err=1.
